// File: rtl/x1_sram_responder.sv
// x1_sram_responder
//   Behavioural model of the X1 external SRAM (two 16-bit chips seen as one
//   32-bit, byte-laned array) plus an ioctl download loader that shares the
//   array's single write port.
//
// Ports:
//   I_CLK, I_RESET           clock, asynchronous active-high reset
//   I_SRAM_A / I_SRAM_D      word address / write byte (replicated to 4 lanes)
//   O_SRAM_D                 registered read data {B ub, B lb, A ub, A lb}
//   I_SRAM_WE / I_SRAM_OE    write strobe (rising edge writes) / read enable
//   I_SRAM_BW                byte-lane enables, bit n -> bits 8n+7:8n
//   I_DL, I_DL_WR            download active / byte strobe
//   I_DL_ADDR, I_DL_DATA     download byte address / byte
//   I_DL_INDEX               download index, only DL_INDEX is accepted
//   O_DL_WAIT                loader buffer occupied, host must hold off
//   O_DL_ERR                 sticky overrun flag, cleared only by reset
module x1_sram_responder #(
  parameter int unsigned DEPTH_W  = 18,
  parameter int unsigned READ_LAT = 1,
  parameter logic [7:0]  DL_INDEX = 8'h00,
  parameter int unsigned DL_BASE  = 0
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic [17:0] I_SRAM_A,
  input  logic [7:0]  I_SRAM_D,
  output logic [31:0] O_SRAM_D,
  input  logic        I_SRAM_WE,
  input  logic        I_SRAM_OE,
  input  logic [3:0]  I_SRAM_BW,
  input  logic        I_DL,
  input  logic        I_DL_WR,
  input  logic [24:0] I_DL_ADDR,
  input  logic [7:0]  I_DL_DATA,
  input  logic [7:0]  I_DL_INDEX,
  output logic        O_DL_WAIT,
  output logic        O_DL_ERR
);

  // Zero at time zero, never touched by reset.
  logic [31:0] mem [2**DEPTH_W] = '{default: '0};

  logic [DEPTH_W-1:0] sram_word;
  logic [DEPTH_W-1:0] dl_target;
  logic               we_d;
  logic               wr_ev;
  logic               dl_accept;
  logic               dl_commit;

  logic               dl_valid;
  logic [DEPTH_W-1:0] dl_word;
  logic [1:0]         dl_lane;
  logic [7:0]         dl_data;
  logic               dl_err;

  logic [31:0] rd_pipe [READ_LAT];

  always_comb begin
    sram_word = DEPTH_W'(I_SRAM_A);
    dl_target = DEPTH_W'(DL_BASE) + DEPTH_W'(I_DL_ADDR >> 2);
    wr_ev     = I_SRAM_WE & ~we_d;
    dl_accept = I_DL & I_DL_WR & (I_DL_INDEX == DL_INDEX);
    // SRAM write events own the write port; the buffer takes any free cycle.
    dl_commit = dl_valid & ~wr_ev;
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      we_d <= 1'b0;
    end else begin
      we_d <= I_SRAM_WE;
    end
  end

  // Array write port: no reset, but suppressed while reset is held.
  always_ff @(posedge I_CLK) begin
    if (!I_RESET) begin
      if (wr_ev) begin
        for (int unsigned n = 0; n < 4; n++) begin
          if (I_SRAM_BW[n]) mem[sram_word][8*n +: 8] <= I_SRAM_D;
        end
      end else if (dl_commit) begin
        mem[dl_word][8*dl_lane +: 8] <= dl_data;
      end
    end
  end

  // Read pipe: nonblocking update gives read-before-write on collisions,
  // and the whole pipe stalls while OE is low.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      for (int unsigned i = 0; i < READ_LAT; i++) rd_pipe[i] <= '0;
    end else if (I_SRAM_OE) begin
      rd_pipe[0] <= mem[sram_word];
      for (int unsigned i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign O_SRAM_D = rd_pipe[READ_LAT-1];

  // One-entry loader buffer. A new byte may land in the same cycle the old
  // one commits; otherwise a byte arriving on a full buffer is dropped.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      dl_valid <= 1'b0;
      dl_word  <= '0;
      dl_lane  <= '0;
      dl_data  <= '0;
      dl_err   <= 1'b0;
    end else begin
      if (dl_accept && (!dl_valid || dl_commit)) begin
        dl_valid <= 1'b1;
        dl_word  <= dl_target;
        dl_lane  <= I_DL_ADDR[1:0];
        dl_data  <= I_DL_DATA;
      end else if (dl_commit) begin
        dl_valid <= 1'b0;
      end
      if (dl_accept && dl_valid && !dl_commit) dl_err <= 1'b1;
    end
  end

  assign O_DL_WAIT = dl_valid;
  assign O_DL_ERR  = dl_err;

endmodule

// File: tb/tb_x1_sram_responder.sv
module tb_x1_sram_responder;

  localparam int unsigned RL   = 1;
  localparam logic [7:0]  IDX  = 8'h03;
  localparam int unsigned BASE = 'h100;

  logic        I_CLK = 1'b0;
  logic        I_RESET = 1'b0;
  logic [17:0] I_SRAM_A = '0;
  logic [7:0]  I_SRAM_D = '0;
  logic [31:0] O_SRAM_D;
  logic        I_SRAM_WE = 1'b0;
  logic        I_SRAM_OE = 1'b0;
  logic [3:0]  I_SRAM_BW = '0;
  logic        I_DL = 1'b0;
  logic        I_DL_WR = 1'b0;
  logic [24:0] I_DL_ADDR = '0;
  logic [7:0]  I_DL_DATA = '0;
  logic [7:0]  I_DL_INDEX = '0;
  logic        O_DL_WAIT;
  logic        O_DL_ERR;

  int n_tests = 0;
  int n_fail  = 0;

  x1_sram_responder #(
    .DEPTH_W (18),
    .READ_LAT(RL),
    .DL_INDEX(IDX),
    .DL_BASE (BASE)
  ) dut (
    .I_CLK     (I_CLK),
    .I_RESET   (I_RESET),
    .I_SRAM_A  (I_SRAM_A),
    .I_SRAM_D  (I_SRAM_D),
    .O_SRAM_D  (O_SRAM_D),
    .I_SRAM_WE (I_SRAM_WE),
    .I_SRAM_OE (I_SRAM_OE),
    .I_SRAM_BW (I_SRAM_BW),
    .I_DL      (I_DL),
    .I_DL_WR   (I_DL_WR),
    .I_DL_ADDR (I_DL_ADDR),
    .I_DL_DATA (I_DL_DATA),
    .I_DL_INDEX(I_DL_INDEX),
    .O_DL_WAIT (O_DL_WAIT),
    .O_DL_ERR  (O_DL_ERR)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic sram_wr(input logic [17:0] a, input logic [7:0] d, input logic [3:0] bw);
    I_SRAM_A = a; I_SRAM_D = d; I_SRAM_BW = bw; I_SRAM_WE = 1'b1;
    step();
    I_SRAM_WE = 1'b0;
    step();
  endtask

  task automatic sram_rd(input string tag, input logic [17:0] a, input logic [31:0] exp);
    I_SRAM_A = a; I_SRAM_OE = 1'b1;
    for (int i = 0; i < int'(RL); i++) step();
    I_SRAM_OE = 1'b0;
    chk(tag, O_SRAM_D, exp);
  endtask

  task automatic dl_byte(input logic [24:0] a, input logic [7:0] d, input logic [7:0] idx);
    I_DL_ADDR = a; I_DL_DATA = d; I_DL_INDEX = idx; I_DL_WR = 1'b1;
    step();
    I_DL_WR = 1'b0;
    step();
  endtask

  initial begin
    // 1. asynchronous reset mid-cycle
    step(); step();
    #2 I_RESET = 1'b1;
    #1;
    chk("rst_rdata", O_SRAM_D, 32'h0);
    chk("rst_wait", {31'h0, O_DL_WAIT}, 32'h0);
    chk("rst_err", {31'h0, O_DL_ERR}, 32'h0);
    step(); step();
    I_RESET = 1'b0;
    step();
    sram_rd("rd_addr0", 18'h0, 32'h0);

    // 2. byte lanes
    sram_wr(18'h00010, 8'hA5, 4'b0101);
    sram_rd("lane_0101", 18'h00010, 32'h00A500A5);
    sram_wr(18'h00010, 8'h3C, 4'b1000);
    sram_rd("lane_1000", 18'h00010, 32'h3CA500A5);

    // read pipe holds while OE is low
    I_SRAM_A = 18'h0;
    step(); step();
    chk("oe_hold", O_SRAM_D, 32'h3CA500A5);

    // 3. one write per strobe
    I_SRAM_A = 18'h00020; I_SRAM_D = 8'h11; I_SRAM_BW = 4'hF; I_SRAM_WE = 1'b1;
    step();
    I_SRAM_D = 8'h22;
    step(); step(); step(); step();
    I_SRAM_WE = 1'b0;
    step();
    sram_rd("single_wr", 18'h00020, 32'h11111111);

    // read-before-write at the same address in the same cycle
    I_SRAM_A = 18'h00010; I_SRAM_D = 8'h00; I_SRAM_BW = 4'hF;
    I_SRAM_OE = 1'b1; I_SRAM_WE = 1'b1;
    step();
    chk("rbw_old", O_SRAM_D, 32'h3CA500A5);
    I_SRAM_WE = 1'b0;
    step();
    chk("rbw_new", O_SRAM_D, 32'h00000000);
    I_SRAM_OE = 1'b0;
    step();

    // 4. download, matching index; wait is high for exactly one cycle
    I_DL = 1'b1;
    I_DL_ADDR = 25'd0; I_DL_DATA = 8'h11; I_DL_INDEX = IDX; I_DL_WR = 1'b1;
    step();
    I_DL_WR = 1'b0;
    chk("dl_wait_hi", {31'h0, O_DL_WAIT}, 32'h1);
    step();
    chk("dl_wait_lo", {31'h0, O_DL_WAIT}, 32'h0);
    dl_byte(25'd1, 8'h22, IDX);
    dl_byte(25'd2, 8'h33, IDX);
    dl_byte(25'd3, 8'h44, IDX);
    sram_rd("dl_word", 18'h00100, 32'h44332211);
    chk("dl_err_clean", {31'h0, O_DL_ERR}, 32'h0);
    // wrong index is ignored
    dl_byte(25'd0, 8'hAA, IDX + 8'd1);
    dl_byte(25'd1, 8'hBB, IDX + 8'd1);
    dl_byte(25'd2, 8'hCC, IDX + 8'd1);
    dl_byte(25'd3, 8'hDD, IDX + 8'd1);
    sram_rd("dl_bad_index", 18'h00100, 32'h44332211);

    // 5. collision: SRAM write event blocks the pending download byte
    I_DL_ADDR = 25'd4; I_DL_DATA = 8'h5A; I_DL_INDEX = IDX; I_DL_WR = 1'b1;
    step();
    I_DL_WR = 1'b0;
    chk("col_wait1", {31'h0, O_DL_WAIT}, 32'h1);
    I_SRAM_A = 18'h00200; I_SRAM_D = 8'h77; I_SRAM_BW = 4'hF; I_SRAM_WE = 1'b1;
    step();
    I_SRAM_WE = 1'b0;
    chk("col_wait2", {31'h0, O_DL_WAIT}, 32'h1);
    step();
    chk("col_wait_end", {31'h0, O_DL_WAIT}, 32'h0);
    sram_rd("col_dl_word", 18'h00101, 32'h0000005A);
    sram_rd("col_sram_word", 18'h00200, 32'h77777777);

    // 6. overrun while the buffer is blocked
    I_DL_ADDR = 25'd8; I_DL_DATA = 8'h66; I_DL_WR = 1'b1;
    step();
    I_DL_ADDR = 25'd9; I_DL_DATA = 8'h99;
    I_SRAM_A = 18'h00201; I_SRAM_D = 8'h12; I_SRAM_BW = 4'hF; I_SRAM_WE = 1'b1;
    step();
    I_DL_WR = 1'b0; I_SRAM_WE = 1'b0;
    chk("ovr_err", {31'h0, O_DL_ERR}, 32'h1);
    chk("ovr_wait", {31'h0, O_DL_WAIT}, 32'h1);
    step();
    chk("ovr_wait_end", {31'h0, O_DL_WAIT}, 32'h0);
    sram_rd("ovr_dropped", 18'h00102, 32'h00000066);
    sram_rd("ovr_sram", 18'h00201, 32'h12121212);

    // reset while a byte is pending
    I_DL_ADDR = 25'd12; I_DL_DATA = 8'hEE; I_DL_WR = 1'b1;
    step();
    I_DL_WR = 1'b0;
    chk("pend_wait", {31'h0, O_DL_WAIT}, 32'h1);
    #2 I_RESET = 1'b1;
    #1;
    chk("pend_rst_wait", {31'h0, O_DL_WAIT}, 32'h0);
    chk("pend_rst_err", {31'h0, O_DL_ERR}, 32'h0);
    // strobe already high when reset releases: counts as one write
    I_SRAM_A = 18'h00300; I_SRAM_D = 8'hC3; I_SRAM_BW = 4'b0001; I_SRAM_WE = 1'b1;
    step(); step();
    I_RESET = 1'b0;
    step();
    I_SRAM_WE = 1'b0;
    I_DL = 1'b0;
    step();
    sram_rd("pend_discard", 18'h00103, 32'h0);
    sram_rd("rst_we_high", 18'h00300, 32'h000000C3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
